cordic_arb: RTL
===============

Name: cordic_arb

Overview:
- Round-robin scheduler that shares one cordic_mod instance (theta in, sin/cos out, fixed 20-cycle latency, no backpressure) between NUM_REQ requesters.
- Drives the CORDIC issue port and tags each issue with its requester ID in an in-order tag FIFO.
- Buffers returned results in a response FIFO and presents them on a single ID-tagged valid/ready response port.
- Reserves buffer space at issue, so no CORDIC result is ever overwritten or dropped.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); ID_W = clog2(NUM_REQ), derived localparam.
- DEPTH, 8, tag/response FIFO depth and max outstanding operations; power of 2.
- ISSUE_GAP, 2, minimum cycles between successive CORDIC issues (>=2, so single-cycle result pulses never collide).
- WDOG_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester request valid
- req_theta  in  NUM_REQ*32  per-requester theta; requester i uses bits [32i+31:32i]; format matches cordic_mod theta
- req_rdy  out  NUM_REQ  one-hot grant; a request is accepted when req_vld[i] & req_rdy[i]
- cdc_theta  out  32  theta to CORDIC
- cdc_vld  out  1  issue strobe to CORDIC (rand_shake)
- cdc_rdy  out  1  result ready to CORDIC (rdy_i)
- cdc_res_vld  in  1  CORDIC vld_o
- cdc_sin  in  32  CORDIC i_signal_o
- cdc_cos  in  32  CORDIC r_signal_o
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_id  out  ID_W  requester ID of the response
- rsp_sin  out  32  sin result
- rsp_cos  out  32  cos result
- err_orphan  out  1  sticky: CORDIC result arrived with no outstanding tag

Behaviour:
- Reset (async, rst_n low): req_rdy=0, cdc_vld=0, cdc_theta=0, cdc_rdy=0, rsp_vld=0, rsp_id/sin/cos=0, err_orphan=0.
  - RR pointer resets to 0; FIFOs empty; outstanding=0; gap counter=0.
  - cdc_rdy goes to 1 on the first clock after reset release and stays 1.
- Outstanding count = tag FIFO occupancy + response FIFO occupancy, range 0..DEPTH.
- Issue eligibility, all required: outstanding<DEPTH, gap counter==0, any req_vld set.
- Grant selection:
  - Round-robin, starting at the RR pointer. req_rdy is combinational from registered state and the current req_vld, and is at most one-hot.
  - On accept: RR pointer <= granted index+1 (wraps to 0).
  - Non-granted requesters keep req_rdy=0 and hold their request.
- Issue timing: accept at cycle T.
  - T+1: cdc_vld=1 for exactly one cycle, cdc_theta=accepted theta (held until next issue); tag ID pushed to tag FIFO at the T edge.
  - Gap counter loads ISSUE_GAP-1 and decrements to 0.
  - Next accept no earlier than T+ISSUE_GAP.
- Result capture when cdc_res_vld & cdc_rdy:
  - Pop tag FIFO; push {tag,cdc_sin,cdc_cos} into the response FIFO.
  - If the tag FIFO is empty: set err_orphan (sticky until reset), push nothing, outstanding unchanged.
- Response port:
  - rsp_vld is high while the response FIFO is non-empty; rsp_* show the head entry, registered.
  - Pop on rsp_vld & rsp_rdy. rsp_* hold stable while rsp_vld & ~rsp_rdy.
  - Responses return in issue order. Nominal latency: accept T -> rsp_vld at T+22 when the FIFO was empty.
- Simultaneous events:
  - Issue + response pop in the same cycle: outstanding unchanged.
  - Result capture moves an entry between FIFOs; outstanding unchanged.
  - Result capture + pop of the same FIFO in one cycle is legal; FIFOs support simultaneous read and write when non-empty.
- Full: outstanding==DEPTH -> all req_rdy=0 until a response pops. Pointers wrap modulo DEPTH.
- Reset mid-operation: all in-flight state is discarded. cordic_mod shares rst_n, so no stale result can return.

Optional Feature:
- Macro CORDIC_ARB_WDOG_EN.
- Defined:
  - Adds output err_timeout (1 bit, reset 0, sticky).
  - A counter runs while the tag FIFO is non-empty; it clears on every result capture and when the tag FIFO empties.
  - On reaching WDOG_CYC: err_timeout=1, and issue is blocked (req_rdy=0) until reset.
- Undefined: no err_timeout port, no counter; behaviour otherwise identical.

Test Plan:
- Single request: req_vld[1]=1, theta=30<<16 at T; CORDIC model returns sin=0x8000, cos=0xDDB3 -> cdc_vld pulse at T+1; rsp_vld at T+22 with rsp_id=1, rsp_sin=0x8000, rsp_cos=0xDDB3.
- All four requesters held valid, rsp_rdy=1 -> grants 0,1,2,3,0,1 at cycles T, T+2, T+4, ...; response IDs arrive in the same order, 2 cycles apart.
- rsp_rdy=0, continuous requests -> exactly 8 accepts, then req_rdy=0 indefinitely. One rsp_rdy pulse -> exactly one further accept; rsp_id order preserved.
- cdc_res_vld pulse with no outstanding issue -> err_orphan=1, rsp_vld stays 0; subsequent normal traffic still completes correctly.
- rst_n low while 3 ops are in flight -> all outputs return to reset values immediately. After release, a new request completes with outstanding starting from 0.
- With CORDIC_ARB_WDOG_EN and WDOG_CYC=64: issue one request, model never returns a result -> err_timeout=1 at 64 cycles after the tag push, and req_rdy held 0 thereafter.

Source files
------------

// File: rtl/cordic_arb.sv
// Round-robin scheduler sharing one fixed-latency CORDIC between NUM_REQ requesters.
// Define CORDIC_ARB_WDOG_EN to add the err_timeout watchdog output.
module cordic_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 8,
`ifdef CORDIC_ARB_WDOG_EN
  parameter int WDOG_CYC  = 64,
`endif
  parameter int ISSUE_GAP = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*32-1:0]      req_theta,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [31:0]                cdc_theta,
  output logic                       cdc_vld,
  output logic                       cdc_rdy,
  input  logic                       cdc_res_vld,
  input  logic [31:0]                cdc_sin,
  input  logic [31:0]                cdc_cos,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_sin,
  output logic [31:0]                rsp_cos,
`ifdef CORDIC_ARB_WDOG_EN
  output logic                       err_timeout,
`endif
  output logic                       err_orphan
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int GW   = $clog2(ISSUE_GAP);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     sin;
    logic [31:0]     cos;
  } rsp_t;

  logic [ID_W-1:0]            rr_q, rr_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic                       cdc_vld_q, cdc_vld_d, cdc_rdy_q, cdc_rdy_d;
  logic [31:0]                cdc_theta_q, cdc_theta_d;
  logic [DEPTH-1:0][ID_W-1:0] tag_mem_q, tag_mem_d;
  logic [AW-1:0]              tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0]              rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]              tag_cnt_q, tag_cnt_d, rsp_cnt_q, rsp_cnt_d, outst;
  rsp_t [DEPTH-1:0]           rsp_mem_q, rsp_mem_d;
  logic                       err_orphan_q, err_orphan_d;
  logic                       gnt_found, can_issue, accept, capture, cap_ok, pop, issue_blk;
  logic [ID_W-1:0]            gnt_idx;
  logic [ID_W:0]              cand;

  // First valid requester at or after the RR pointer, modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && req_vld[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Outstanding counts both FIFOs, so a result always has a response slot reserved.
  assign outst     = tag_cnt_q + rsp_cnt_q;
  assign can_issue = cdc_rdy_q & (outst < CW'(DEPTH)) & (gap_q == '0) & ~issue_blk;
  assign accept    = can_issue & gnt_found;
  assign capture   = cdc_res_vld & cdc_rdy_q;
  assign cap_ok    = capture & (tag_cnt_q != '0);
  assign pop       = rsp_vld & rsp_rdy;

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d         = rr_q;
    gap_d        = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    cdc_vld_d    = accept;
    cdc_rdy_d    = 1'b1;
    cdc_theta_d  = cdc_theta_q;
    tag_mem_d    = tag_mem_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    tag_cnt_d    = tag_cnt_q;
    rsp_mem_d    = rsp_mem_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_rd_d     = rsp_rd_q;
    rsp_cnt_d    = rsp_cnt_q;
    err_orphan_d = err_orphan_q | (capture & (tag_cnt_q == '0));
    if (accept) begin
      rr_d                = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      gap_d               = GW'(ISSUE_GAP-1);
      cdc_theta_d         = req_theta[{gnt_idx, 5'b0} +: 32];
      tag_mem_d[tag_wr_q] = gnt_idx;
      tag_wr_d            = tag_wr_q + 1'b1;
    end
    if (cap_ok) begin
      tag_rd_d            = tag_rd_q + 1'b1;
      rsp_mem_d[rsp_wr_q] = rsp_t'{id: tag_mem_q[tag_rd_q], sin: cdc_sin, cos: cdc_cos};
      rsp_wr_d            = rsp_wr_q + 1'b1;
    end
    if (pop) rsp_rd_d = rsp_rd_q + 1'b1;
    case ({accept, cap_ok})
      2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
    case ({cap_ok, pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      gap_q        <= '0;
      cdc_vld_q    <= 1'b0;
      cdc_rdy_q    <= 1'b0;
      cdc_theta_q  <= '0;
      tag_mem_q    <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      rsp_mem_q    <= '0;
      rsp_wr_q     <= '0;
      rsp_rd_q     <= '0;
      rsp_cnt_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      gap_q        <= gap_d;
      cdc_vld_q    <= cdc_vld_d;
      cdc_rdy_q    <= cdc_rdy_d;
      cdc_theta_q  <= cdc_theta_d;
      tag_mem_q    <= tag_mem_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      tag_cnt_q    <= tag_cnt_d;
      rsp_mem_q    <= rsp_mem_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_cnt_q    <= rsp_cnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

`ifdef CORDIC_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC+1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_timeout_q, err_timeout_d;

  always_comb begin
    wdog_d = wdog_q;
    if (cap_ok || tag_cnt_q == '0) wdog_d = '0;
    else if (wdog_q != WW'(WDOG_CYC)) wdog_d = wdog_q + 1'b1;
    err_timeout_d = err_timeout_q | (wdog_d == WW'(WDOG_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign issue_blk   = err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  assign issue_blk = 1'b0;
`endif

  assign cdc_vld    = cdc_vld_q;
  assign cdc_rdy    = cdc_rdy_q;
  assign cdc_theta  = cdc_theta_q;
  assign rsp_vld    = (rsp_cnt_q != '0);
  assign {rsp_id, rsp_sin, rsp_cos} = rsp_mem_q[rsp_rd_q];
  assign err_orphan = err_orphan_q;
endmodule
